bram_rom_arbiter: RTL and testbench
===================================

Name: bram_rom_arbiter

Overview:
- Shares one single-port synchronous-read BRAM ROM (1-cycle registered read) between two requesters: A (instruction fetch) and B (data/constant load).
- Per-requester req/gnt handshake plus a read-valid return path.
- Fair round-robin arbitration, with an optional lock for back-to-back bursts.
- Sits between the CPU fetch/load units and the ROM instance. One access issued per cycle, fully pipelined.

Parameters:
- memSize_p, 8, ROM address width in bits (depth 2**memSize_p).
- dataWidth_p, 16, ROM data word width in bits.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- a_req_i  input  1  requester A read request; held with a_addr_i until granted.
- a_addr_i  input  memSize_p  requester A word address.
- a_lock_i  input  1  A asks to keep ownership for its next request.
- a_gnt_o  output  1  A's request accepted this cycle (combinational).
- a_rvalid_o  output  1  a_rdata_o holds A's read data this cycle.
- a_rdata_o  output  dataWidth_p  read data to A.
- b_req_i, b_addr_i, b_lock_i, b_gnt_o, b_rvalid_o, b_rdata_o: same as A, for requester B.
- rom_addr_o  output  memSize_p  address to ROM (sampled by ROM at clock edge).
- rom_data_i  input  dataWidth_p  ROM registered data, valid the cycle after address.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low. While rst_ni=0 and at the first edge after:
  - a_gnt_o=b_gnt_o=0 (forced low even if requests are present)
  - a_rvalid_o=b_rvalid_o=0
  - rom_addr_o=0
  - owner state = NONE
  - last_grant pointer = B, so A wins the first tie.
- State machine, owner ∈ {NONE, OWN_A, OWN_B}:
  - NONE: grant goes to the sole requester. If both request, grant the one not equal to last_grant (round-robin).
  - OWN_A: A is entered when A is granted with a_lock_i=1. While in OWN_A, any cycle with a_req_i=1 grants A regardless of b_req_i. Leave to NONE when A is granted with a_lock_i=0, or on any cycle with a_req_i=0. That cycle is arbitrated as NONE, so B may be granted in the same cycle.
  - OWN_B: symmetric.
- Grant is combinational from req/owner/last_grant. At most one gnt high per cycle. gnt is never high without the matching req.
- Addressing:
  - Grant cycle N: rom_addr_o = granted requester's address.
  - No grant: rom_addr_o holds the last granted address (registered copy), so no spurious toggling.
- Return path:
  - Cycle N+1: x_rvalid_o=1 for the requester granted in N, and only that one.
  - a_rdata_o = b_rdata_o = rom_data_i, passed through combinationally. Data is meaningful only when the matching rvalid is high.
- Latency and throughput:
  - Fixed 1 cycle from gnt to rvalid.
  - One grant per cycle sustained. A and B interleave ABAB when both request continuously, unlocked.
- last_grant updates on every grant.
- Simultaneous events: a new grant and the previous cycle's rvalid coexist in the same cycle (pipelined, no bubble).
- Reset mid-operation: an in-flight response is discarded (no rvalid after reset), and owner and pointer are reinitialised.
- Requester obligations: hold req and addr stable until gnt. Dropping req before gnt is permitted and cancels the request; no response follows.
- Widths: addresses pass unmodified; no wrap logic. Addressing above 2**memSize_p-1 is impossible by width.

Test Plan:
- Reset then A only: a_req=1, addr 0x05 in cycle 1 -> a_gnt=1 cycle 1, rom_addr_o=0x05, a_rvalid=1 cycle 2 with rdata=mem[0x05]; b_* outputs stay 0.
- Both request continuously, no lock, A addr 0x10, B addr 0x20 -> grants A,B,A,B from the first post-reset cycle; rvalid alternates one cycle later with mem[0x10]/mem[0x20].
- Lock burst: A requests 0x00..0x03 with a_lock=1 on the first three and 0 on the last, B requesting throughout -> four consecutive A grants, then B granted the next cycle; B never granted during the burst.
- Lock release on req drop: OWN_A, then a_req=0 for one cycle with b_req=1 -> b_gnt=1 that same cycle; owner returns to NONE.
- Idle hold: grant A addr 0x33, then no requests for 5 cycles -> rom_addr_o stays 0x33, no gnt, no rvalid after the first response.
- Reset mid-flight: grant B addr 0x44 in cycle N, rst_ni=0 in cycle N+1 -> b_rvalid_o=0 in N+1; after release both tie -> A granted first.

Source files
------------

// File: rtl/bram_rom_arbiter.sv
// ---------------------------------------------------------------------------
// bram_rom_arbiter
//
// Shares one single-port, synchronous-read BRAM ROM (registered read, data
// valid the cycle after the address) between two requesters:
//   A - instruction fetch, B - data/constant load.
// One access is issued per cycle and the path is fully pipelined: a grant in
// cycle N produces the matching rvalid in cycle N+1. A new grant and the
// previous cycle's response can coexist in the same cycle.
//
// Handshake (applies to both requesters):
//   x_req_i/x_addr_i are held stable by the requester until x_gnt_o is high.
//   x_gnt_o is combinational and only ever high with x_req_i high. Dropping
//   x_req_i before the grant cancels the request. A grant in cycle N is
//   answered by x_rvalid_o=1 in cycle N+1, with x_rdata_o carrying the ROM
//   word for that cycle only.
//
// Arbitration:
//   Round-robin between A and B using a last-grant pointer (reset to B so A
//   wins the first tie). A requester granted with x_lock_i=1 becomes the
//   owner and wins every cycle it keeps requesting. Ownership ends when the
//   owner is granted with lock low, or on any cycle the owner is not
//   requesting; that cycle is arbitrated as unowned.
//
// Ports:
//   clk_i        system clock, all state on rising edge
//   rst_ni       synchronous active-low reset
//   a_req_i      A read request
//   a_addr_i     A word address
//   a_lock_i     A keeps ownership for its next request
//   a_gnt_o      A request accepted this cycle (combinational)
//   a_rvalid_o   a_rdata_o holds A's read data this cycle
//   a_rdata_o    read data to A (ROM data passed through)
//   b_*          same set for requester B
//   rom_addr_o   address to the ROM, sampled at the clock edge
//   rom_data_i   registered ROM data, valid the cycle after the address
// ---------------------------------------------------------------------------
module bram_rom_arbiter #(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   a_req_i,
    input  logic [memSize_p-1:0]   a_addr_i,
    input  logic                   a_lock_i,
    output logic                   a_gnt_o,
    output logic                   a_rvalid_o,
    output logic [dataWidth_p-1:0] a_rdata_o,

    input  logic                   b_req_i,
    input  logic [memSize_p-1:0]   b_addr_i,
    input  logic                   b_lock_i,
    output logic                   b_gnt_o,
    output logic                   b_rvalid_o,
    output logic [dataWidth_p-1:0] b_rdata_o,

    output logic [memSize_p-1:0]   rom_addr_o,
    input  logic [dataWidth_p-1:0] rom_data_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    // Complete arbiter state in one place so it can be observed as a unit.
    typedef struct packed {
        owner_e owner;
        logic   last_b;   // 1: last grant went to B, 0: to A
    } arb_state_t;

    arb_state_t             state_q;
    logic                   a_rvalid_q;
    logic                   b_rvalid_q;
    logic [memSize_p-1:0]   addr_q;

    logic                   a_gnt_d;
    logic                   b_gnt_d;

    // Grant decision. An owner that has stopped requesting falls through to
    // the unowned arbitration in the same cycle, so the other side can win.
    always_comb begin
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
        if (rst_ni) begin
            if (state_q.owner == OWN_A && a_req_i) begin
                a_gnt_d = 1'b1;
            end else if (state_q.owner == OWN_B && b_req_i) begin
                b_gnt_d = 1'b1;
            end else if (a_req_i && b_req_i) begin
                a_gnt_d = state_q.last_b;
                b_gnt_d = ~state_q.last_b;
            end else begin
                a_gnt_d = a_req_i;
                b_gnt_d = b_req_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q.owner  <= OWN_NONE;
            state_q.last_b <= 1'b1;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            addr_q         <= '0;
        end else begin
            a_rvalid_q <= a_gnt_d;
            b_rvalid_q <= b_gnt_d;
            if (a_gnt_d) begin
                state_q.owner  <= a_lock_i ? OWN_A : OWN_NONE;
                state_q.last_b <= 1'b0;
                addr_q         <= a_addr_i;
            end else if (b_gnt_d) begin
                state_q.owner  <= b_lock_i ? OWN_B : OWN_NONE;
                state_q.last_b <= 1'b1;
                addr_q         <= b_addr_i;
            end else begin
                // No grant means the owner (if any) was not requesting.
                state_q.owner  <= OWN_NONE;
            end
        end
    end

    assign a_gnt_o = a_gnt_d;
    assign b_gnt_o = b_gnt_d;

    // Holding the last granted address on idle cycles avoids needless ROM
    // address toggling.
    always_comb begin
        rom_addr_o = addr_q;
        if (!rst_ni) begin
            rom_addr_o = '0;
        end else if (a_gnt_d) begin
            rom_addr_o = a_addr_i;
        end else if (b_gnt_d) begin
            rom_addr_o = b_addr_i;
        end
    end

    // rvalid is masked by reset so a response in flight when reset arrives
    // is dropped in the reset cycle itself.
    assign a_rvalid_o = a_rvalid_q & rst_ni;
    assign b_rvalid_o = b_rvalid_q & rst_ni;
    assign a_rdata_o  = rom_data_i;
    assign b_rdata_o  = rom_data_i;

endmodule

// File: tb/tb_bram_rom_arbiter.sv
module tb_bram_rom_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_lock, b_req, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    // Scoreboard: bit DW is the requester (0=A, 1=B), low bits the ROM word.
    logic [DW:0]   exp_q[$];
    int            n_cmp;
    int            n_bad;

    bram_rom_arbiter #(.memSize_p(AW), .dataWidth_p(DW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .a_req_i    (a_req),
        .a_addr_i   (a_addr),
        .a_lock_i   (a_lock),
        .a_gnt_o    (a_gnt),
        .a_rvalid_o (a_rvalid),
        .a_rdata_o  (a_rdata),
        .b_req_i    (b_req),
        .b_addr_i   (b_addr),
        .b_lock_i   (b_lock),
        .b_gnt_o    (b_gnt),
        .b_rvalid_o (b_rvalid),
        .b_rdata_o  (b_rdata),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents as a pure function of the address.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // ROM with a one-cycle registered read.
    always_ff @(posedge clk) rom_data <= mem_f(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge,
    // record the expected response of any grant made this cycle.
    task automatic cyc(input logic rst, input logic ar, input logic [AW-1:0] aa, input logic al,
                       input logic br, input logic [AW-1:0] ba, input logic bl,
                       input logic ea, input logic eb, input logic [AW-1:0] eaddr);
        logic [DW:0]   e;
        logic          ev_a, ev_b;
        logic [DW-1:0] ed;
        rst_n  = rst;
        a_req  = ar; a_addr = aa; a_lock = al;
        b_req  = br; b_addr = ba; b_lock = bl;
        if (!rst) exp_q.delete();
        ev_a = 1'b0; ev_b = 1'b0; ed = '0;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            ev_a = ~e[DW];
            ev_b = e[DW];
            ed   = e[DW-1:0];
        end
        @(negedge clk);
        chk("a_gnt", 32'(a_gnt), 32'(ea));
        chk("b_gnt", 32'(b_gnt), 32'(eb));
        chk("rom_addr", 32'(rom_addr), 32'(eaddr));
        chk("a_rvalid", 32'(a_rvalid), 32'(ev_a));
        chk("b_rvalid", 32'(b_rvalid), 32'(ev_b));
        if (ev_a) chk("a_rdata", 32'(a_rdata), 32'(ed));
        if (ev_b) chk("b_rdata", 32'(b_rdata), 32'(ed));
        if (ea) exp_q.push_back({1'b0, mem_f(eaddr)});
        if (eb) exp_q.push_back({1'b1, mem_f(eaddr)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a_req = 1'b0; a_addr = '0; a_lock = 1'b0;
        b_req = 1'b0; b_addr = '0; b_lock = 1'b0;
        @(posedge clk);
        #1;

        // Reset: grants forced low even with both requesting.
        cyc(0, 1, 8'h11, 0, 1, 8'h22, 0,  0, 0, 8'h00);
        cyc(0, 1, 8'h11, 0, 1, 8'h22, 0,  0, 0, 8'h00);

        // A only, addr 0x05, then idle to collect the response.
        cyc(1, 1, 8'h05, 0, 0, 8'h00, 0,  1, 0, 8'h05);
        cyc(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h05);

        // Fresh reset, then both continuously unlocked: A,B,A,B.
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h00);
        cyc(1, 1, 8'h10, 0, 1, 8'h20, 0,  1, 0, 8'h10);
        cyc(1, 1, 8'h10, 0, 1, 8'h20, 0,  0, 1, 8'h20);
        cyc(1, 1, 8'h10, 0, 1, 8'h20, 0,  1, 0, 8'h10);
        cyc(1, 1, 8'h10, 0, 1, 8'h20, 0,  0, 1, 8'h20);
        cyc(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h20);

        // Locked burst of four from A while B keeps requesting.
        cyc(1, 1, 8'h00, 1, 1, 8'h21, 0,  1, 0, 8'h00);
        cyc(1, 1, 8'h01, 1, 1, 8'h21, 0,  1, 0, 8'h01);
        cyc(1, 1, 8'h02, 1, 1, 8'h21, 0,  1, 0, 8'h02);
        cyc(1, 1, 8'h03, 0, 1, 8'h21, 0,  1, 0, 8'h03);
        cyc(1, 0, 8'h00, 0, 1, 8'h21, 0,  0, 1, 8'h21);
        cyc(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h21);

        // Lock released by dropping req: B wins in the same cycle.
        cyc(1, 1, 8'h07, 1, 1, 8'h22, 0,  1, 0, 8'h07);
        cyc(1, 1, 8'h08, 1, 1, 8'h22, 0,  1, 0, 8'h08);
        cyc(1, 0, 8'h00, 0, 1, 8'h22, 0,  0, 1, 8'h22);
        cyc(1, 1, 8'h09, 0, 1, 8'h23, 0,  1, 0, 8'h09);
        cyc(1, 1, 8'h09, 0, 1, 8'h23, 0,  0, 1, 8'h23);
        cyc(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h23);

        // Idle hold after a single A grant.
        cyc(1, 1, 8'h33, 0, 0, 8'h00, 0,  1, 0, 8'h33);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h33);
        end

        // Reset with a B response in flight: dropped; A wins the first tie.
        cyc(1, 0, 8'h00, 0, 1, 8'h44, 0,  0, 1, 8'h44);
        cyc(0, 1, 8'h55, 0, 1, 8'h66, 0,  0, 0, 8'h00);
        cyc(1, 1, 8'h55, 0, 1, 8'h66, 0,  1, 0, 8'h55);
        cyc(1, 0, 8'h00, 0, 1, 8'h66, 0,  0, 1, 8'h66);
        cyc(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 8'h66);

        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
